// File: rtl/lsu_mem_master.sv
// Load/store unit initiator for the mem_req / mem_addr_ok / mem_data_ok data-memory protocol.
// One transaction in flight at a time; illegal or misaligned accesses never reach memory.
module lsu_mem_master #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned MW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // Pipeline request
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic          lsu_we,
  input  logic [2:0]    lsu_funct3,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_wdata,
  // Pipeline response
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  // Memory side
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [MW-1:0] mem_wem,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok
);

  localparam int unsigned OffW = $clog2(MW);

  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3BU = 3'b100;
  localparam logic [2:0] F3HU = 3'b101;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e state_q, state_d;

  logic            we_q;
  logic [2:0]      funct3_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            err_q;
  logic [DW-1:0]   rdata_q;

  logic            illegal;
  logic            accept;
  logic [OffW-1:0] off;
  logic [DW-1:0]   rdata_shift;
  logic [DW-1:0]   load_ext;
  logic [DW-1:0]   store_data;
  logic [MW-1:0]   store_wem;

  assign accept = (state_q == StIdle) && lsu_valid;
  assign off    = addr_q[OffW-1:0];

  // Legality is judged on the live request so the error path can skip REQ entirely.
  always_comb begin
    illegal = 1'b0;
    case (lsu_funct3)
      F3B:        illegal = 1'b0;
      F3H:        illegal = lsu_addr[0];
      F3W:        illegal = (lsu_addr[OffW-1:0] != '0);
      F3BU, F3HU: illegal = lsu_we;
      default:    illegal = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (lsu_valid) begin
          state_d = illegal ? StResp : StReq;
        end
      end
      StReq: begin
        if (mem_addr_ok) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_data_ok) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request capture and response data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else if (accept) begin
      we_q     <= lsu_we;
      funct3_q <= lsu_funct3;
      addr_q   <= lsu_addr;
      wdata_q  <= lsu_wdata;
      err_q    <= illegal;
      rdata_q  <= '0;
    end else if ((state_q == StWait) && mem_data_ok) begin
      rdata_q  <= we_q ? '0 : load_ext;
    end
  end

  // Halfword lanes are always even-aligned once legal, so one byte-granular shift covers both.
  assign rdata_shift = mem_rdata >> {off, 3'b000};

  always_comb begin
    load_ext = mem_rdata;
    case (funct3_q)
      F3B:     load_ext = {{(DW-8){rdata_shift[7]}}, rdata_shift[7:0]};
      F3BU:    load_ext = {{(DW-8){1'b0}}, rdata_shift[7:0]};
      F3H:     load_ext = {{(DW-16){rdata_shift[15]}}, rdata_shift[15:0]};
      F3HU:    load_ext = {{(DW-16){1'b0}}, rdata_shift[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    store_data = wdata_q;
    store_wem  = '1;
    case (funct3_q[1:0])
      2'b00: begin
        store_data = {MW{wdata_q[7:0]}};
        store_wem  = MW'(1) << off;
      end
      2'b01: begin
        store_data = {(MW/2){wdata_q[15:0]}};
        store_wem  = MW'(3) << off;
      end
      default: begin
        store_data = wdata_q;
        store_wem  = '1;
      end
    endcase
  end

  // Outputs: everything except lsu_ready idles at zero outside its own state.
  always_comb begin
    lsu_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wem   = '0;
    unique case (state_q)
      StIdle: lsu_ready = 1'b1;
      StReq: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = {addr_q[AW-1:OffW], {OffW{1'b0}}};
        mem_wdata = we_q ? store_data : '0;
        mem_wem   = we_q ? store_wem : '0;
      end
      StWait: begin
      end
      StResp: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed accesses push expected memory requests and
// responses; negedge monitors pop and compare whatever the DUT presents.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_funct3 = 3'b000;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wem;
  logic [31:0] mem_rdata = '0;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;

  lsu_mem_master #(.AW(32), .DW(32), .MW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_we      (lsu_we),
    .lsu_funct3  (lsu_funct3),
    .lsu_addr    (lsu_addr),
    .lsu_wdata   (lsu_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wem     (mem_wem),
    .mem_rdata   (mem_rdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wem;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Request monitor: every REQ cycle must match the head entry; the handshake retires it.
  always @(negedge clk) begin
    req_t e;
    if (rst_n && mem_req) begin
      if (req_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_mem_req: got mem_req=1 addr=%h, expected no request", mem_addr);
      end else begin
        e = req_q[0];
        check("mem_we", {31'b0, mem_we}, {31'b0, e.we});
        check("mem_addr", mem_addr, e.addr);
        check("mem_wdata", mem_wdata, e.wdata);
        check("mem_wem", {28'b0, mem_wem}, {28'b0, e.wem});
        if (mem_addr_ok) void'(req_q.pop_front());
      end
    end
  end

  // Response monitor: content plus the exact cycle the pulse must appear.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && rsp_valid) begin
      if (rsp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h err=%0d, expected none",
                 rsp_rdata, rsp_err);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        check("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_lsu_ready"}, {31'b0, lsu_ready}, 32'd1);
    check({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
    check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_wem"}, {28'b0, mem_wem}, 32'd0);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
  endtask

  // Called at posedge+1 with the DUT idle; d = cycles mem_addr_ok is withheld.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int d,
                        input logic exp_err, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_wem, input logic [31:0] exp_rdata);
    int acc;
    int k;
    if (!exp_err) req_q.push_back('{we, {addr[31:2], 2'b00}, exp_wdata, exp_wem});
    lsu_valid  = 1'b1;
    lsu_we     = we;
    lsu_funct3 = f3;
    lsu_addr   = addr;
    lsu_wdata  = wdata;
    @(posedge clk); #1;
    acc = cyc;
    rsp_q.push_back('{exp_rdata, exp_err, exp_err ? acc : acc + d + 2});
    lsu_valid  = 1'b0;
    lsu_we     = 1'b0;
    lsu_funct3 = 3'b000;
    lsu_addr   = '0;
    lsu_wdata  = '0;
    check("lsu_ready_busy", {31'b0, lsu_ready}, 32'd0);
    if (!exp_err) begin
      for (int i = 0; i < d; i++) begin
        @(posedge clk); #1;
      end
      mem_addr_ok = 1'b1;
      @(posedge clk); #1;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1;
      mem_rdata   = rdata;
      @(posedge clk); #1;
      mem_data_ok = 1'b0;
      mem_rdata   = '0;
    end
    k = 0;
    while (!lsu_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("lsu_ready_return", {31'b0, lsu_ready}, 32'd1);
    check("lsu_ready_latency", 32'(k), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    //     we    f3      addr          wdata         mem_rdata     d  err   exp_wdata     wem      exp_rdata
    access(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0);
    access(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        0, 1'b0, 32'hA5A5_A5A5, 4'b1000, 32'h0);
    access(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0,        5, 1'b0, 32'h1234_1234, 4'b1100, 32'h0);
    access(1'b1, 3'b001, 32'h0000_0100, 32'hFFFF_5678, 32'h0,        1, 1'b0, 32'h5678_5678, 4'b0011, 32'h0);
    access(1'b0, 3'b000, 32'h0000_0202, 32'h0,        32'h80F1_7F00, 0, 1'b0, 32'h0,        4'b0000, 32'hFFFF_FFF1);
    access(1'b0, 3'b100, 32'h0000_0203, 32'h0,        32'h80F1_7F00, 0, 1'b0, 32'h0,        4'b0000, 32'h0000_0080);
    access(1'b0, 3'b001, 32'h0000_0202, 32'h0,        32'h80F1_7F00, 0, 1'b0, 32'h0,        4'b0000, 32'hFFFF_80F1);
    access(1'b0, 3'b101, 32'h0000_0200, 32'h0,        32'h80F1_7F00, 0, 1'b0, 32'h0,        4'b0000, 32'h0000_7F00);
    access(1'b0, 3'b000, 32'h0000_0200, 32'h0,        32'h80F1_7F00, 0, 1'b0, 32'h0,        4'b0000, 32'h0000_0000);
    access(1'b0, 3'b010, 32'h0000_0204, 32'h0,        32'h1357_9BDF, 2, 1'b0, 32'h0,        4'b0000, 32'h1357_9BDF);
    access(1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0);
    access(1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0);
    access(1'b0, 3'b110, 32'h0000_0100, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0);
    access(1'b1, 3'b100, 32'h0000_0100, 32'h0000_0011, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0);
    access(1'b1, 3'b101, 32'h0000_0100, 32'h0000_0011, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0);
    access(1'b0, 3'b001, 32'h0000_0201, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0);

    // Stray mem_data_ok while idle must not produce a response.
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    check_idle("stray_data_ok");

    // Reset while waiting for data: the late mem_data_ok must be ignored.
    req_q.push_back('{1'b0, 32'h0000_0300, 32'h0, 4'b0000});
    lsu_valid  = 1'b1;
    lsu_funct3 = 3'b010;
    lsu_addr   = 32'h0000_0300;
    @(posedge clk); #1;
    lsu_valid  = 1'b0;
    lsu_funct3 = 3'b000;
    lsu_addr   = '0;
    mem_addr_ok = 1'b1;
    @(posedge clk); #1;
    mem_addr_ok = 1'b0;
    rst_n = 1'b0;
    #2;
    check_idle("in_reset");
    rst_n = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h1111_2222;
    @(posedge clk); #1;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    check_idle("after_reset");
    @(posedge clk); #1;
    check_idle("after_reset2");

    access(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h0BAD_CAFE, 0, 1'b0, 32'h0, 4'b0000,
           32'h0BAD_CAFE);

    repeat (3) @(posedge clk);
    #1;
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
